// File: rtl/seq_word_adder.sv
// seq_word_adder: streams two WORDS*WIDTH-bit operands through a single
// WIDTH-bit adder slice, least-significant word first, chaining the carry
// between beats in a register. One output register stage, no skid buffer.
// Optional feature: define SEQ_ADD_SUB_EN to add the in_sub port, which turns
// the packet into A-B (out_cout=1 means no borrow).
module seq_word_adder #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             carry_reg;
  logic             accept;
  logic             beat_last;
  logic             carry_src;
  logic             sub_active;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   slice_sum;
`ifdef SEQ_ADD_SUB_EN
  logic             sub_reg;
`endif

  // A new beat may enter whenever the output register is empty or draining.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // State register: packet phase, beat counter, chained carry, packet mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      carry_reg <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
      if (accept) begin
        carry_reg <= slice_sum[WIDTH];
`ifdef SEQ_ADD_SUB_EN
        sub_reg   <= sub_active;
`endif
      end
    end
  end

  // Next-state logic: count accepted beats and return to IDLE after the last.
  always_comb begin
    state_next = state;
    cnt_next   = beat_cnt;
    if (accept) begin
      case (state)
        IDLE: begin
          if (WORDS > 1) begin
            state_next = RUN;
            cnt_next   = CNT_W'(1);
          end
        end
        RUN: begin
          if (beat_cnt == LAST_CNT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Slice datapath: pick the carry source and operand polarity, then add.
  always_comb begin
    beat_last = (state == IDLE) ? (WORDS == 1) : (beat_cnt == LAST_CNT);
`ifdef SEQ_ADD_SUB_EN
    sub_active = (state == IDLE) ? in_sub : sub_reg;
    carry_src  = (state == IDLE) ? (in_sub | in_cin) : carry_reg;
`else
    sub_active = 1'b0;
    carry_src  = (state == IDLE) ? in_cin : carry_reg;
`endif
    b_eff     = sub_active ? ~in_b : in_b;
    slice_sum = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_src};
  end

  // Output register: load on an accepted beat, empty when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= slice_sum[WIDTH-1:0];
      out_last  <= beat_last;
      out_cout  <= beat_last ? slice_sum[WIDTH] : 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_word_adder.sv
// Self-checking bench for seq_word_adder (WIDTH=4, WORDS=4). Expected slices
// come from whole-packet arithmetic done in the bench; a negedge monitor
// compares every output transfer and every stalled cycle.
module tb_seq_word_adder;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int TOT   = WIDTH * WORDS;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             last;
    logic             cout;
  } slice_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_cout;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  bit use_gaps = 0;

  slice_t           exp_q[$];
  logic [TOT-1:0]   got_word = '0;
  logic [TOT-1:0]   got_last_word = '0;
  logic             got_last_cout = 1'b0;
  int               got_idx = 0;

  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_last;
  logic             prev_cout;

  seq_word_adder #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SEQ_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  // Whole-operand result: bits [TOT-1:0] are the sum, bit TOT the carry-out.
  function automatic logic [TOT:0] modelResult(input logic [TOT-1:0] a,
                                               input logic [TOT-1:0] b,
                                               input logic cin,
                                               input logic sub);
    if (sub)
      return {1'b0, a} + {1'b0, ~b} + (TOT+1)'(1);
    else
      return {1'b0, a} + {1'b0, b} + (TOT+1)'(cin);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected progress at %0t", name, $time);
  endtask

  // Downstream acceptance pattern, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)
      out_ready = 1'b1;
    else if (ready_mode == 1)
      out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares each output transfer and each stalled cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      checkOutput("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_hold) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_sum", 32'(out_sum), 32'(prev_sum));
        checkOutput("hold_last", 32'(out_last), 32'(prev_last));
        checkOutput("hold_cout", 32'(out_cout), 32'(prev_cout));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_slice", 32'(out_valid), 32'd0);
        end else begin
          slice_t e;
          e = exp_q.pop_front();
          checkOutput("slice_sum", 32'(out_sum), 32'(e.sum));
          checkOutput("slice_last", 32'(out_last), 32'(e.last));
          checkOutput("slice_cout", 32'(out_cout), 32'(e.cout));
        end
        got_word[got_idx*WIDTH +: WIDTH] = out_sum;
        got_idx++;
        if (out_last || got_idx >= WORDS) begin
          got_last_word = got_word;
          got_last_cout = out_cout;
          got_idx = 0;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_last = out_last;
      prev_cout = out_cout;
    end
  end

  // Queue the expected slices of one packet and drive its first nbeats beats.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                               input logic cin, input logic sub, input int nbeats);
    logic [TOT:0] r;
    r = modelResult(a, b, cin, sub);
    for (int i = 0; i < WORDS; i++) begin
      slice_t s;
      s.sum  = r[i*WIDTH +: WIDTH];
      s.last = (i == WORDS - 1);
      s.cout = (i == WORDS - 1) ? r[TOT] : 1'b0;
      exp_q.push_back(s);
    end
    for (int i = 0; i < nbeats; i++) begin
      int t;
      if (use_gaps) begin
        int g;
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_a     = a[i*WIDTH +: WIDTH];
      in_b     = b[i*WIDTH +: WIDTH];
      in_cin   = (i == 0) ? cin : 1'($urandom);
      in_sub   = (i == 0) ? sub : 1'($urandom);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        failNow("beat_accept");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      failNow("drain");
      exp_q.delete();
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_during_rst", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_idx = 0;
    @(negedge clk);
    checkOutput("valid_after_rst", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Pin the model with hand-computed values.
    checkOutput("model_mixed", 32'(modelResult(16'h3A9C, 16'h1234, 1'b1, 1'b0)), 32'h04CD1);
    checkOutput("model_ripple", 32'(modelResult(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
    checkOutput("model_sub", 32'(modelResult(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_cout", 32'(out_cout), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero operands.
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, WORDS);
    waitDrain();
    checkOutput("zero_word", 32'(got_last_word), 32'h0000);
    checkOutput("zero_cout", 32'(got_last_cout), 32'd0);

    // Carry ripples through every slice.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, WORDS);
    waitDrain();
    checkOutput("ripple_word", 32'(got_last_word), 32'h0000);
    checkOutput("ripple_cout", 32'(got_last_cout), 32'd1);

    // Mixed packet followed back-to-back by one that must not inherit carry.
    applyStimulus(16'h3A9C, 16'h1234, 1'b1, 1'b0, WORDS);
    applyStimulus(16'h0001, 16'h0000, 1'b0, 1'b0, WORDS);
    waitDrain();
    checkOutput("noleak_word", 32'(got_last_word), 32'h0001);
    checkOutput("noleak_cout", 32'(got_last_cout), 32'd0);

    // Backpressure: stall while the second slice is presented.
    ready_mode = 2;
    out_ready  = 1'b1;
    fork
      applyStimulus(16'h3A9C, 16'h1234, 1'b1, 1'b0, WORDS);
      begin
        int t;
        t = 0;
        while (!(out_valid && got_idx == 1) && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (!(out_valid && got_idx == 1)) begin
          failNow("bp_second_slice");
        end else begin
          out_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            checkOutput("bp_sum", 32'(out_sum), 32'hD);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_word", 32'(got_last_word), 32'h4CD1);
    checkOutput("bp_cout", 32'(got_last_cout), 32'd0);
    ready_mode = 0;

    // Reset after two accepted beats, then a clean packet.
    applyStimulus(16'h3A9C, 16'h1234, 1'b1, 1'b0, 2);
    pulseReset();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, WORDS);
    waitDrain();
    checkOutput("rst_word", 32'(got_last_word), 32'h0000);
    checkOutput("rst_cout", 32'(got_last_cout), 32'd1);

`ifdef SEQ_ADD_SUB_EN
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, WORDS);
    waitDrain();
    checkOutput("sub_neg_word", 32'(got_last_word), 32'hFFFE);
    checkOutput("sub_neg_cout", 32'(got_last_cout), 32'd0);
    applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, WORDS);
    waitDrain();
    checkOutput("sub_pos_word", 32'(got_last_word), 32'h0002);
    checkOutput("sub_pos_cout", 32'(got_last_cout), 32'd1);
`endif

    // Randomized packets with random gaps and random downstream stalls.
    ready_mode = 1;
    use_gaps   = 1;
    for (int p = 0; p < 60; p++) begin
      logic sub;
`ifdef SEQ_ADD_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      applyStimulus(TOT'($urandom), TOT'($urandom), 1'($urandom), sub, WORDS);
    end
    ready_mode = 0;
    use_gaps   = 0;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
